cms_axis_downsizer: RTL and testbench
=====================================

# cms_axis_downsizer

Packs the 96-bit trace items ({pc, instr}) emitted by `continuous_monitoring_system` on its `M_AXIS` port into a 64-bit AXI-Stream for the DMA/FIFO path. Two consecutive items become three fully packed 64-bit beats. An input `tlast` flushes any partial word as a padded beat, so packet boundaries are preserved. The block also provides free-running item and beat counters for software bandwidth checks.

## Interface
- `XLEN`, 64, PC width; only 64 is supported, so the input item is `XLEN+32` = 96 bits.
- `OUT_WIDTH`, 64, output beat width; only 64 is supported.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `S_AXIS_tvalid`  in  1  input item valid.
- `S_AXIS_tready`  out  1  block accepts an item this cycle.
- `S_AXIS_tdata`  in  96  item; bits [31:0] = instr, bits [95:32] = pc.
- `S_AXIS_tlast`  in  1  last item of packet.
- `M_AXIS_tvalid`  out  1  output beat valid.
- `M_AXIS_tready`  in  1  downstream accepts beat.
- `M_AXIS_tdata`  out  64  packed beat; lower byte lanes carry earlier stream bytes.
- `M_AXIS_tkeep`  out  8  byte enables; either 8'hFF or 8'h0F.
- `M_AXIS_tlast`  out  1  last beat of packet.
- `items_count`  out  32  number of accepted input items, wrapping.
- `beats_count`  out  32  number of accepted output beats, wrapping.

## Operation
- Output is a single registered slot. `slot_free = !M_AXIS_tvalid || M_AXIS_tready`.
- `res` is a 64-bit residue register. `pend_last` is a 1-bit flag.
- States and transitions (each load of the slot sets `M_AXIS_tvalid` = 1):
  - `P0` (no residue): `S_AXIS_tready = slot_free`. On accepting item A:
    - slot ← A[63:0], keep FF, last 0.
    - res[31:0] ← A[95:64].
    - Go to `FLUSH` if A.tlast, else `P1`.
  - `P1` (32-bit residue held): `S_AXIS_tready = slot_free`. On accepting item B:
    - slot ← {B[31:0], res[31:0]}, keep FF, last 0.
    - res ← B[95:32]; pend_last ← B.tlast.
    - Go to `P2`.
  - `P2`: `S_AXIS_tready` = 0. When slot_free:
    - slot ← res, keep FF, last ← pend_last.
    - Go to `P0`.
  - `FLUSH`: `S_AXIS_tready` = 0. When slot_free:
    - slot ← {32'h0, res[31:0]}, keep 0F, last 1.
    - Go to `P0`.
- Any state: if slot_free and nothing is loaded, `M_AXIS_tvalid` ← 0.
- `M_AXIS_tdata`/`tkeep`/`tlast` are held stable while `tvalid && !tready`.
- `items_count` increments on each `S_AXIS_tvalid && S_AXIS_tready`.
- `beats_count` increments on each `M_AXIS_tvalid && M_AXIS_tready`.
- Both counters wrap from 32'hFFFFFFFF to 0.
- `tlast` on an item accepted in `P1` yields exactly three beats for the pair, with the last one flagged. No padding is needed.
- An item arriving with no `tlast` at end of stream stays buffered in `P1` indefinitely. Upstream guarantees `tlast` through its `tlast_interval`.

## Timing
- Reset values: state `P0`; `M_AXIS_tvalid` 0, `M_AXIS_tdata` 0, `M_AXIS_tkeep` 0, `M_AXIS_tlast` 0; `res` 0; `pend_last` 0; both counters 0. `S_AXIS_tready` is combinational and equals 1 in `P0` after reset.
- Latency: item accepted at edge N → its first beat is valid after edge N (visible in cycle N+1).
- Throughput with `M_AXIS_tready` held at 1: 2 items per 3 cycles. Output `tvalid` is continuous when input `tvalid` is continuous.
- Simultaneous output handshake and input accept in the same cycle is legal. The slot is reloaded with no bubble.
- `S_AXIS_tready` depends combinationally on `M_AXIS_tready`. There is no combinational path from `S_AXIS_tvalid` to any output.
- Reset asserted mid-packet: the residue is discarded, outputs clear asynchronously, and the block restarts in `P0`.

## Test plan
- Two items, tlast on the 2nd: A = {pc 0x8, instr 0x6f}, B = {pc 0xC, instr 0x67}, tready=1 → three beats:
  - 64'h00000008_0000006f, keep FF, last 0;
  - 64'h00000067_00000000, keep FF, last 0;
  - 64'h00000000_0000000C, keep FF, last 1;
  - then items_count=2, beats_count=3.
- Single item with tlast: A = {pc 0x10, instr 0x13} → two beats:
  - 64'h00000010_00000013, keep FF, last 0;
  - 64'h0, keep 0F, last 1.
- Back-pressure: M_AXIS_tready=0 for 5 cycles mid-pair → the beat is held stable, S_AXIS_tready=0, no data is lost. After release, the beat order is identical to the first scenario.
- Streaming: 6 items with tlast every 3rd (the upstream tlast_interval=3), continuous valid, tready=1 → 10 beats total:
  - tlast on beats 5 and 10;
  - beats 5 and 10 have keep 0F;
  - no idle output cycles within a packet.
- Reset asserted while in `P2` → tvalid=0 immediately. After release the next item starts a fresh beat 0 and counters read 0.
- Counter wrap: preload by running 2^32 items (or force) → items_count rolls from FFFFFFFF to 0 without disturbing data.

Source files
------------

// File: rtl/cms_axis_downsizer.sv
// -----------------------------------------------------------------------------
// cms_axis_downsizer
//
// Packs 96-bit trace items ({pc[63:0], instr[31:0]}) into a 64-bit AXI-Stream.
// Two consecutive items become three fully packed beats. An item carrying
// tlast closes the packet: if it leaves a 32-bit residue, that residue goes
// out as a zero-padded beat with tkeep = 8'h0F. Lower byte lanes of each beat
// carry earlier stream bytes. Free-running wrapping counters report accepted
// items and accepted beats.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   S_AXIS_tvalid/ready item handshake (tready is combinational on state and
//                       M_AXIS_tready only, never on S_AXIS_tvalid)
//   S_AXIS_tdata        item: [31:0] = instr, [95:32] = pc
//   S_AXIS_tlast        last item of packet
//   M_AXIS_tvalid/ready beat handshake (registered output slot)
//   M_AXIS_tdata        packed 64-bit beat
//   M_AXIS_tkeep        8'hFF for full beats, 8'h0F for the padded flush beat
//   M_AXIS_tlast        last beat of packet
//   items_count         accepted input items, wraps at 2^32
//   beats_count         accepted output beats, wraps at 2^32
//
// Only XLEN = 64 and OUT_WIDTH = 64 are supported.
// -----------------------------------------------------------------------------
module cms_axis_downsizer #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned OUT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   S_AXIS_tvalid,
    output logic                   S_AXIS_tready,
    input  logic [XLEN+31:0]       S_AXIS_tdata,
    input  logic                   S_AXIS_tlast,

    output logic                   M_AXIS_tvalid,
    input  logic                   M_AXIS_tready,
    output logic [OUT_WIDTH-1:0]   M_AXIS_tdata,
    output logic [OUT_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                   M_AXIS_tlast,

    output logic [31:0]            items_count,
    output logic [31:0]            beats_count
);

    // P0:    no residue held
    // P1:    upper 32 bits of the previous item held in res_q[31:0]
    // P2:    a full 64-bit residue (pc of the second item) waits for the slot
    // FLUSH: a 32-bit residue must go out as a padded final beat
    typedef enum logic [1:0] {
        ST_P0    = 2'd0,
        ST_P1    = 2'd1,
        ST_P2    = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   res_q, res_d;
    logic                   pend_last_q, pend_last_d;

    logic                   m_valid_q, m_valid_d;
    logic [OUT_WIDTH-1:0]   m_data_q, m_data_d;
    logic [OUT_WIDTH/8-1:0] m_keep_q, m_keep_d;
    logic                   m_last_q, m_last_d;

    logic [31:0]            items_count_q, items_count_d;
    logic [31:0]            beats_count_q, beats_count_d;

    logic                   slot_free;
    logic                   s_ready;
    logic                   s_accept;
    logic                   m_accept;

    // The slot may be (re)loaded whenever it is empty or being drained this
    // cycle, which is what lets a beat handshake and a new load share a cycle.
    assign slot_free = !m_valid_q || M_AXIS_tready;
    assign m_accept  = m_valid_q && M_AXIS_tready;

    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        pend_last_d = pend_last_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        s_ready     = 1'b0;
        s_accept    = 1'b0;

        // Drained and not refilled below: slot goes empty.
        if (slot_free) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_P0: begin
                s_ready = slot_free;
                if (slot_free && S_AXIS_tvalid) begin
                    s_accept       = 1'b1;
                    m_valid_d      = 1'b1;
                    m_data_d       = S_AXIS_tdata[63:0];
                    m_keep_d       = '1;
                    m_last_d       = 1'b0;
                    res_d[31:0]    = S_AXIS_tdata[95:64];
                    state_d        = S_AXIS_tlast ? ST_FLUSH : ST_P1;
                end
            end

            ST_P1: begin
                s_ready = slot_free;
                if (slot_free && S_AXIS_tvalid) begin
                    s_accept    = 1'b1;
                    m_valid_d   = 1'b1;
                    m_data_d    = {S_AXIS_tdata[31:0], res_q[31:0]};
                    m_keep_d    = '1;
                    m_last_d    = 1'b0;
                    res_d       = S_AXIS_tdata[95:32];
                    pend_last_d = S_AXIS_tlast;
                    state_d     = ST_P2;
                end
            end

            ST_P2: begin
                if (slot_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = res_q;
                    m_keep_d  = '1;
                    m_last_d  = pend_last_q;
                    state_d   = ST_P0;
                end
            end

            ST_FLUSH: begin
                if (slot_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = {32'h0, res_q[31:0]};
                    m_keep_d  = 8'h0F;
                    m_last_d  = 1'b1;
                    state_d   = ST_P0;
                end
            end

            default: begin
                state_d = ST_P0;
            end
        endcase

        items_count_d = items_count_q + {31'd0, s_accept};
        beats_count_d = beats_count_q + {31'd0, m_accept};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_P0;
            res_q         <= '0;
            pend_last_q   <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_keep_q      <= '0;
            m_last_q      <= 1'b0;
            items_count_q <= '0;
            beats_count_q <= '0;
        end else begin
            state_q       <= state_d;
            res_q         <= res_d;
            pend_last_q   <= pend_last_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_keep_q      <= m_keep_d;
            m_last_q      <= m_last_d;
            items_count_q <= items_count_d;
            beats_count_q <= beats_count_d;
        end
    end

    assign S_AXIS_tready = s_ready;
    assign M_AXIS_tvalid = m_valid_q;
    assign M_AXIS_tdata  = m_data_q;
    assign M_AXIS_tkeep  = m_keep_q;
    assign M_AXIS_tlast  = m_last_q;
    assign items_count   = items_count_q;
    assign beats_count   = beats_count_q;

endmodule

// File: tb/tb_cms_axis_downsizer.sv
// -----------------------------------------------------------------------------
// Bench for cms_axis_downsizer. Expected beats come from a byte-stream model:
// each packet is the concatenation of its items' 12 bytes (instr first, then
// pc, little-endian), cut into 8-byte beats, final partial beat zero-padded.
// -----------------------------------------------------------------------------
module tb_cms_axis_downsizer;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        S_AXIS_tvalid = 1'b0;
    logic        S_AXIS_tready;
    logic [95:0] S_AXIS_tdata = '0;
    logic        S_AXIS_tlast = 1'b0;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tready = 1'b0;
    logic [63:0] M_AXIS_tdata;
    logic [7:0]  M_AXIS_tkeep;
    logic        M_AXIS_tlast;
    logic [31:0] items_count;
    logic [31:0] beats_count;

    always #5 clk = ~clk;

    cms_axis_downsizer #(
        .XLEN      (64),
        .OUT_WIDTH (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (S_AXIS_tready),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tlast  (S_AXIS_tlast),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tkeep  (M_AXIS_tkeep),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .items_count   (items_count),
        .beats_count   (beats_count)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_items = '0;
    logic [31:0] exp_beats = '0;

    logic [95:0] in_data[$];
    logic        in_last[$];
    beat_t       exp_q[$];
    beat_t       got[$];
    int          hold_viol;
    int          idle_in_stream;
    bit          timed_out;

    // Byte-stream reference model.
    function automatic void build_expected();
        logic [7:0] bytes[$];
        beat_t      b;
        exp_q.delete();
        for (int i = 0; i < in_data.size(); i++) begin
            for (int k = 0; k < 12; k++) bytes.push_back(in_data[i][8*k +: 8]);
            if (in_last[i]) begin
                while (bytes.size() > 0) begin
                    b = '0;
                    for (int j = 0; j < 8; j++) begin
                        if (bytes.size() > 0) begin
                            b.data[8*j +: 8] = bytes.pop_front();
                            b.keep[j]        = 1'b1;
                        end
                    end
                    b.last = (bytes.size() == 0);
                    exp_q.push_back(b);
                end
            end
        end
    endfunction

    // Drives in_data/in_last and captures beats; expected count is exp_q.size().
    task automatic run_stream(input int ready_pct, input int gap_pct, input int max_cycles);
        int    dcyc;
        int    mcyc;
        bit    acc;
        bit    held;
        beat_t hb;
        beat_t cur;
        got.delete();
        hold_viol      = 0;
        idle_in_stream = 0;
        timed_out      = 1'b0;
        dcyc           = 0;
        mcyc           = 0;
        held           = 1'b0;
        hb             = '0;
        fork
            begin
                for (int i = 0; i < in_data.size(); i++) begin
                    @(posedge clk); #1;
                    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                        S_AXIS_tvalid = 1'b0;
                        @(posedge clk); #1;
                    end
                    S_AXIS_tvalid = 1'b1;
                    S_AXIS_tdata  = in_data[i];
                    S_AXIS_tlast  = in_last[i];
                    acc = 1'b0;
                    while (!acc) begin
                        @(negedge clk);
                        dcyc++;
                        if (S_AXIS_tready) acc = 1'b1;
                        else if (dcyc > max_cycles) begin
                            timed_out = 1'b1;
                            break;
                        end else begin
                            @(posedge clk); #1;
                        end
                    end
                    if (timed_out) break;
                end
                @(posedge clk); #1;
                S_AXIS_tvalid = 1'b0;
                S_AXIS_tlast  = 1'b0;
            end
            begin
                while (got.size() < exp_q.size() && mcyc < max_cycles) begin
                    @(posedge clk); #1;
                    M_AXIS_tready = ($urandom_range(99) < ready_pct);
                    @(negedge clk);
                    mcyc++;
                    cur = {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast};
                    if (held && (!M_AXIS_tvalid || cur != hb)) hold_viol++;
                    if (got.size() > 0 && !M_AXIS_tvalid) idle_in_stream++;
                    held = M_AXIS_tvalid && !M_AXIS_tready;
                    hb   = cur;
                    if (M_AXIS_tvalid && M_AXIS_tready) got.push_back(cur);
                end
                if (got.size() < exp_q.size()) timed_out = 1'b1;
                @(posedge clk); #1;
                M_AXIS_tready = 1'b1;
            end
        join
    endtask

    task automatic test_reset();
        checks++;
        if (M_AXIS_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b want=0", M_AXIS_tvalid); end
        checks++;
        if (M_AXIS_tdata !== 64'h0) begin failures++; $display("FAIL reset_tdata got=%h want=0", M_AXIS_tdata); end
        checks++;
        if (M_AXIS_tkeep !== 8'h00) begin failures++; $display("FAIL reset_tkeep got=%h want=00", M_AXIS_tkeep); end
        checks++;
        if (M_AXIS_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b want=0", M_AXIS_tlast); end
        checks++;
        if (S_AXIS_tready !== 1'b1) begin failures++; $display("FAIL reset_s_tready got=%b want=1", S_AXIS_tready); end
        checks++;
        if (items_count !== 32'h0) begin failures++; $display("FAIL reset_items got=%h want=0", items_count); end
        checks++;
        if (beats_count !== 32'h0) begin failures++; $display("FAIL reset_beats got=%h want=0", beats_count); end
    endtask

    task automatic test_pair();
        beat_t want[3];
        want[0] = {64'h00000008_0000006f, 8'hFF, 1'b0};
        want[1] = {64'h00000067_00000000, 8'hFF, 1'b0};
        want[2] = {64'h00000000_0000000C, 8'hFF, 1'b1};
        in_data.delete(); in_last.delete();
        in_data.push_back({64'h8, 32'h6f}); in_last.push_back(1'b0);
        in_data.push_back({64'hC, 32'h67}); in_last.push_back(1'b1);
        build_expected();
        run_stream(100, 0, 50);
        exp_items += 2; exp_beats += 3;
        checks++;
        if (got.size() !== 3) begin failures++; $display("FAIL pair_count got=%0d want=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin failures++; $display("FAIL pair_beat%0d got=%h want=%h", i, got[i], want[i]); end
        end
        checks++;
        if (items_count !== exp_items) begin failures++; $display("FAIL pair_items got=%h want=%h", items_count, exp_items); end
        checks++;
        if (beats_count !== exp_beats) begin failures++; $display("FAIL pair_beats got=%h want=%h", beats_count, exp_beats); end
    endtask

    task automatic test_single();
        beat_t want[2];
        want[0] = {64'h00000010_00000013, 8'hFF, 1'b0};
        want[1] = {64'h0, 8'h0F, 1'b1};
        in_data.delete(); in_last.delete();
        in_data.push_back({64'h10, 32'h13}); in_last.push_back(1'b1);
        build_expected();
        run_stream(100, 0, 50);
        exp_items += 1; exp_beats += 2;
        checks++;
        if (got.size() !== 2) begin failures++; $display("FAIL single_count got=%0d want=2", got.size()); end
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin failures++; $display("FAIL single_beat%0d got=%h want=%h", i, got[i], want[i]); end
        end
        checks++;
        if (items_count !== exp_items) begin failures++; $display("FAIL single_items got=%h want=%h", items_count, exp_items); end
        checks++;
        if (beats_count !== exp_beats) begin failures++; $display("FAIL single_beats got=%h want=%h", beats_count, exp_beats); end
    endtask

    task automatic test_backpressure();
        beat_t want[3];
        bit    b_acc;
        want[0] = {64'h00000008_0000006f, 8'hFF, 1'b0};
        want[1] = {64'h00000067_00000000, 8'hFF, 1'b0};
        want[2] = {64'h00000000_0000000C, 8'hFF, 1'b1};
        got.delete();
        @(posedge clk); #1;
        M_AXIS_tready = 1'b0;
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = {64'h8, 32'h6f}; S_AXIS_tlast = 1'b0;
        @(negedge clk);
        checks++;
        if (S_AXIS_tready !== 1'b1) begin failures++; $display("FAIL bp_accept_a got=%b want=1", S_AXIS_tready); end
        @(posedge clk); #1;
        S_AXIS_tdata = {64'hC, 32'h67}; S_AXIS_tlast = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (S_AXIS_tready !== 1'b0) begin failures++; $display("FAIL bp_s_tready cyc%0d got=%b want=0", c, S_AXIS_tready); end
            checks++;
            if (M_AXIS_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid cyc%0d got=%b want=1", c, M_AXIS_tvalid); end
            checks++;
            if ({M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast} !== want[0]) begin
                failures++;
                $display("FAIL bp_hold cyc%0d got=%h want=%h", c, {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast}, want[0]);
            end
            @(posedge clk); #1;
        end
        M_AXIS_tready = 1'b1;
        b_acc = 1'b0;
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            @(negedge clk);
            if (M_AXIS_tvalid) got.push_back({M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast});
            if (S_AXIS_tvalid && S_AXIS_tready) b_acc = 1'b1;
            @(posedge clk); #1;
            if (b_acc) begin S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0; end
        end
        S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0;
        exp_items += 2; exp_beats += 3;
        checks++;
        if (b_acc !== 1'b1) begin failures++; $display("FAIL bp_accept_b got=%b want=1", b_acc); end
        checks++;
        if (got.size() !== 3) begin failures++; $display("FAIL bp_count got=%0d want=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin failures++; $display("FAIL bp_beat%0d got=%h want=%h", i, got[i], want[i]); end
        end
        checks++;
        if (items_count !== exp_items) begin failures++; $display("FAIL bp_items got=%h want=%h", items_count, exp_items); end
        checks++;
        if (beats_count !== exp_beats) begin failures++; $display("FAIL bp_beats got=%h want=%h", beats_count, exp_beats); end
    endtask

    task automatic test_stream();
        in_data.delete(); in_last.delete();
        for (int i = 0; i < 6; i++) begin
            in_data.push_back({$urandom, $urandom, $urandom});
            in_last.push_back((i % 3) == 2);
        end
        build_expected();
        run_stream(100, 0, 100);
        exp_items += 6; exp_beats += 10;
        checks++;
        if (timed_out !== 1'b0) begin failures++; $display("FAIL stream_timeout got=%b want=0", timed_out); end
        checks++;
        if (got.size() !== 10) begin failures++; $display("FAIL stream_count got=%0d want=10", got.size()); end
        if (got.size() >= 10) begin
            checks++;
            if (got[4].last !== 1'b1 || got[4].keep !== 8'h0F) begin
                failures++; $display("FAIL stream_beat5_end got=%h/%b want=0f/1", got[4].keep, got[4].last);
            end
            checks++;
            if (got[9].last !== 1'b1 || got[9].keep !== 8'h0F) begin
                failures++; $display("FAIL stream_beat10_end got=%h/%b want=0f/1", got[9].keep, got[9].last);
            end
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL stream_beat%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        checks++;
        if (idle_in_stream !== 0) begin failures++; $display("FAIL stream_idle got=%0d want=0", idle_in_stream); end
        checks++;
        if (items_count !== exp_items) begin failures++; $display("FAIL stream_items got=%h want=%h", items_count, exp_items); end
        checks++;
        if (beats_count !== exp_beats) begin failures++; $display("FAIL stream_beats got=%h want=%h", beats_count, exp_beats); end
    endtask

    task automatic test_random();
        int n;
        int len;
        in_data.delete(); in_last.delete();
        n = 0;
        while (n < 40) begin
            len = $urandom_range(5, 1);
            for (int k = 0; k < len; k++) begin
                in_data.push_back({$urandom, $urandom, $urandom});
                in_last.push_back(k == len - 1);
            end
            n += len;
        end
        build_expected();
        run_stream(60, 30, 3000);
        exp_items += in_data.size();
        exp_beats += exp_q.size();
        checks++;
        if (timed_out !== 1'b0) begin failures++; $display("FAIL rand_timeout got=%b want=0", timed_out); end
        checks++;
        if (got.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rand_beat%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        checks++;
        if (hold_viol !== 0) begin failures++; $display("FAIL rand_hold got=%0d want=0", hold_viol); end
        checks++;
        if (items_count !== exp_items) begin failures++; $display("FAIL rand_items got=%h want=%h", items_count, exp_items); end
        checks++;
        if (beats_count !== exp_beats) begin failures++; $display("FAIL rand_beats got=%h want=%h", beats_count, exp_beats); end
    endtask

    task automatic test_reset_mid_packet();
        M_AXIS_tready = 1'b1;
        @(posedge clk); #1;
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = {$urandom, $urandom, $urandom}; S_AXIS_tlast = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        S_AXIS_tdata = {$urandom, $urandom, $urandom}; S_AXIS_tlast = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        S_AXIS_tvalid = 1'b0; S_AXIS_tlast = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (M_AXIS_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_tvalid got=%b want=0", M_AXIS_tvalid); end
        checks++;
        if ({M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast} !== 73'h0) begin
            failures++; $display("FAIL rstmid_beat got=%h want=0", {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast});
        end
        checks++;
        if (items_count !== 32'h0 || beats_count !== 32'h0) begin
            failures++; $display("FAIL rstmid_counters got=%h/%h want=0/0", items_count, beats_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_items = '0; exp_beats = '0;
        in_data.delete(); in_last.delete();
        in_data.push_back({$urandom, $urandom, $urandom}); in_last.push_back(1'b1);
        build_expected();
        run_stream(100, 0, 50);
        exp_items += 1; exp_beats += 2;
        checks++;
        if (got.size() !== 2) begin failures++; $display("FAIL rstmid_count got=%0d want=2", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_beat%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        checks++;
        if (items_count !== exp_items) begin failures++; $display("FAIL rstmid_items got=%h want=%h", items_count, exp_items); end
        checks++;
        if (beats_count !== exp_beats) begin failures++; $display("FAIL rstmid_beats got=%h want=%h", beats_count, exp_beats); end
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        force dut.items_count_q = 32'hFFFFFFFF;
        @(posedge clk); #1;
        release dut.items_count_q;
        exp_items = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if (items_count !== exp_items) begin failures++; $display("FAIL wrap_preload got=%h want=%h", items_count, exp_items); end
        in_data.delete(); in_last.delete();
        in_data.push_back({$urandom, $urandom, $urandom}); in_last.push_back(1'b0);
        in_data.push_back({$urandom, $urandom, $urandom}); in_last.push_back(1'b1);
        build_expected();
        run_stream(100, 0, 50);
        exp_items += 2; exp_beats += 3;
        checks++;
        if (items_count !== exp_items) begin failures++; $display("FAIL wrap_items got=%h want=%h", items_count, exp_items); end
        checks++;
        if (got.size() !== 3) begin failures++; $display("FAIL wrap_count got=%0d want=3", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_beat%0d got=%h want=%h", i, got[i], exp_q[i]); end
        end
        checks++;
        if (beats_count !== exp_beats) begin failures++; $display("FAIL wrap_beats got=%h want=%h", beats_count, exp_beats); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_pair();
        test_single();
        test_backpressure();
        test_stream();
        test_random();
        test_reset_mid_packet();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
